// File: rtl/pipelined_carry_skip_adder.sv
// Pipelined carry-skip adder/subtractor: one skip block per pipeline stage,
// valid/ready streaming on both sides, whole pipeline freezes on output stall.
module pipelined_carry_skip_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4,
  localparam int unsigned NBLK = (BLOCK == 0) ? 1 : WIDTH / BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [NBLK-1:0]  skip
);

  localparam int unsigned MSB = WIDTH - 1;

  generate
    if (BLOCK < 1) begin : g_bad_block
      $error("pipelined_carry_skip_adder: BLOCK must be at least 1");
    end else if (WIDTH % BLOCK != 0) begin : g_bad_width
      $error("pipelined_carry_skip_adder: WIDTH must be a multiple of BLOCK");
    end
  endgenerate

  logic             stall;
  logic [NBLK:0]    vld_q;
  logic [NBLK:0]    c_q;
  logic [WIDTH-1:0] a_q    [NBLK];
  logic [WIDTH-1:0] b_q    [NBLK];
  logic [WIDTH-1:0] s_q    [NBLK+1];
  logic [NBLK-1:0]  skip_q [NBLK+1];
  logic             ovf_q;

  logic [WIDTH-1:0] s_n    [NBLK];
  logic [NBLK-1:0]  skip_n [NBLK];
  logic [NBLK-1:0]  c_n;
  logic             ovf_n;

  assign stall     = vld_q[NBLK] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_q[NBLK];
  assign sum       = s_q[NBLK];
  assign cout      = c_q[NBLK];
  assign skip      = skip_q[NBLK];
  assign ovf       = ovf_q;

  // Stage k: ripple block k from c_q[k], then pick the skip or ripple carry-out.
  always_comb begin : blocks
    logic             c;
    logic             p;
    logic [BLOCK-1:0] ba;
    logic [BLOCK-1:0] bb;
    c  = 1'b0;
    p  = 1'b0;
    ba = '0;
    bb = '0;
    for (int k = 0; k < int'(NBLK); k++) begin
      s_n[k]    = s_q[k];
      skip_n[k] = skip_q[k];
      ba        = a_q[k][k*BLOCK +: BLOCK];
      bb        = b_q[k][k*BLOCK +: BLOCK];
      c         = c_q[k];
      p         = 1'b1;
      for (int i = 0; i < int'(BLOCK); i++) begin
        s_n[k][k*BLOCK+i] = ba[i] ^ bb[i] ^ c;
        c                 = (ba[i] & bb[i]) | (c & (ba[i] ^ bb[i]));
        p                 = p & (ba[i] ^ bb[i]);
      end
      c_n[k]       = p ? c_q[k] : c;
      skip_n[k][k] = p;
    end
    ovf_n = (a_q[NBLK-1][MSB] == b_q[NBLK-1][MSB]) &&
            (s_n[NBLK-1][MSB] != a_q[NBLK-1][MSB]);
  end

  // Pipeline registers; every stage holds while the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < int'(NBLK); k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int k = 0; k <= int'(NBLK); k++) begin
        s_q[k]    <= '0;
        skip_q[k] <= '0;
      end
    end else if (!stall) begin
      vld_q     <= {vld_q[NBLK-1:0], in_valid};
      a_q[0]    <= a;
      b_q[0]    <= sub ? ~b : b;
      c_q[0]    <= sub | cin;
      s_q[0]    <= '0;
      skip_q[0] <= '0;
      c_q[NBLK:1] <= c_n;
      ovf_q     <= ovf_n;
      for (int k = 0; k < int'(NBLK); k++) begin
        s_q[k+1]    <= s_n[k];
        skip_q[k+1] <= skip_n[k];
      end
      for (int k = 1; k < int'(NBLK); k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Scoreboard bench for pipelined_carry_skip_adder (WIDTH=16, BLOCK=4).
module tb_pipelined_carry_skip_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned BLOCK = 4;
  localparam int unsigned NBLK  = WIDTH / BLOCK;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [NBLK-1:0]  skip;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [NBLK-1:0]  skip;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic rand_done = 1'b0;

  pipelined_carry_skip_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .skip(skip)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic ci, input logic sb);
    res_t           r;
    logic [WIDTH-1:0] be;
    logic [WIDTH:0]   t;
    logic             c0;
    be = sb ? ~y : y;
    c0 = sb ? 1'b1 : ci;
    t  = {1'b0, x} + {1'b0, be} + (WIDTH+1)'(c0);
    r.sum  = t[WIDTH-1:0];
    r.cout = t[WIDTH];
    r.ovf  = (x[WIDTH-1] == be[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
    for (int k = 0; k < int'(NBLK); k++) r.skip[k] = &(x[k*BLOCK +: BLOCK] ^ be[k*BLOCK +: BLOCK]);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Offer one operand set until accepted; the expected result enters the scoreboard on acceptance.
  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                      input logic ci, input logic sb, input res_t e);
    int   n;
    logic done;
    n = 0;
    done = 1'b0;
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
      n++;
      if (!done && n > 200) begin
        check("accept_timeout", 32'(n), 32'd200);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Send one op into an empty pipe and count cycles from acceptance to out_valid.
  task automatic send_timed(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                            input logic ci, input logic sb, input res_t e);
    int n;
    send(x, y, ci, sb, e);
    n = 1;
    @(posedge clk); #1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(NBLK));
  endtask

  // Monitor: scoreboard compare, output hold during stall, in_ready behaviour.
  initial begin : monitor
    res_t cur;
    res_t prev;
    logic prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        cur = {sum, cout, ovf, skip};
        check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
        if (prev_stall) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", 32'(cur), 32'(prev));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 32'(cur), 32'd0);
            errors += (cur == '0) ? 1 : 0;
          end else begin
            check("result", 32'(cur), 32'(exp_q.pop_front()));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev = cur;
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", 32'({sum, cout, ovf, skip}), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors with hand-derived results
    send_timed(16'h00FF, 16'h0001, 1'b0, 1'b0, '{16'h0100, 1'b0, 1'b0, 4'b0010});
    drain(20);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, '{16'h0000, 1'b1, 1'b0, 4'b1111});
    send(16'h0005, 16'h0007, 1'b1, 1'b1, '{16'hFFFE, 1'b0, 1'b0, 4'b1110});
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1, 4'b0110});
    send(16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1, 4'b0110});
    drain(20);

    // Six back-to-back ops with a three-cycle output stall
    fork
      begin
        send(16'h0001, 16'h0001, 1'b0, 1'b0, '{16'h0002, 1'b0, 1'b0, 4'b0000});
        send(16'h1234, 16'h1111, 1'b0, 1'b0, '{16'h2345, 1'b0, 1'b0, 4'b0000});
        send(16'hF0F0, 16'h0F0F, 1'b1, 1'b0, '{16'h0000, 1'b1, 1'b0, 4'b1111});
        send(16'h0010, 16'h0001, 1'b0, 1'b1, '{16'h000F, 1'b1, 1'b0, 4'b1100});
        send(16'h4000, 16'h4000, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1, 4'b0000});
        send(16'hAAAA, 16'h5555, 1'b0, 1'b0, '{16'hFFFF, 1'b0, 1'b0, 4'b1111});
      end
      begin
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
          @(posedge clk); #1;
          n++;
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 32'd0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain(40);

    // Mid-cycle reset with three ops in flight
    send(16'h1111, 16'h2222, 1'b0, 1'b0, model(16'h1111, 16'h2222, 1'b0, 1'b0));
    send(16'h3333, 16'h4444, 1'b0, 1'b0, model(16'h3333, 16'h4444, 1'b0, 1'b0));
    send(16'h5555, 16'h6666, 1'b0, 1'b0, model(16'h5555, 16'h6666, 1'b0, 1'b0));
    #2 rst = 1'b1;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      check("no_stale_out", 32'(out_valid), 32'd0);
    end
    send_timed(16'h0123, 16'h0456, 1'b0, 1'b0, '{16'h0579, 1'b0, 1'b0, 4'b0000});
    drain(20);

    // Random ops against the reference model with random bubbles and backpressure
    fork
      begin
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic ci;
        logic sb;
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          x  = WIDTH'($urandom);
          y  = WIDTH'($urandom);
          ci = 1'($urandom);
          sb = 1'($urandom);
          send(x, y, ci, sb, model(x, y, ci, sb));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
